// File: rtl/nrisc_control_fsm.sv
// Multi-cycle main control FSM for the nRisc core: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module nrisc_control_fsm #(
    parameter int CNT_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    output logic       alu_op,
    output logic [1:0] func_code,
    output logic [3:0] func_code_r,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       illegal_instr
`ifdef INSTR_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM    = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t state_r;
    state_t next_state_s;

    function automatic logic is_legal_func(input logic [3:0] f);
        case (f)
            4'b1000, 4'b1010, 4'b1101, 4'b1111, 4'b1100: is_legal_func = 1'b1;
            default:                                     is_legal_func = 1'b0;
        endcase
    endfunction

    // State register; reset aborts any pending memory access at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode (FETCH completion also looks at mem_ready)
    always_comb begin
        next_state_s  = state_r;
        alu_op        = 1'b0;
        func_code     = 2'b11;
        func_code_r   = 4'b0000;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        branch        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        halted        = 1'b0;
        illegal_instr = 1'b0;
        case (state_r)
            S_IDLE: begin
                next_state_s = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (ir == 8'hFF) begin
                    next_state_s = S_HALT;
                end else begin
                    case (ir[7:6])
                        2'b00: next_state_s = S_ADDR;
                        2'b01: begin
                            if (is_legal_func(ir[5:2])) begin
                                next_state_s = S_EXEC_R;
                            end else begin
                                illegal_instr = 1'b1;
                                next_state_s  = S_HALT;
                            end
                        end
                        2'b10:   next_state_s = S_BRANCH;
                        2'b11:   next_state_s = S_JUMP;
                        default: next_state_s = S_HALT;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_op       = 1'b1;
                func_code    = 2'b01;
                func_code_r  = ir[5:2];
                next_state_s = S_WB_R;
            end
            S_WB_R: begin
                alu_op       = 1'b1;
                func_code    = 2'b01;
                func_code_r  = ir[5:2];
                reg_write    = 1'b1;
                next_state_s = S_FETCH;
            end
            S_ADDR: begin
                alu_op       = 1'b1;
                func_code    = 2'b00;
                next_state_s = S_MEM;
            end
            S_MEM: begin
                alu_op    = 1'b1;
                func_code = 2'b00;
                i_or_d    = 1'b1;
                mem_read  = ~ir[5];
                mem_write = ir[5];
                if (mem_ready) begin
                    next_state_s = ir[5] ? S_FETCH : S_WB_MEM;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB_MEM: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_op       = 1'b1;
                func_code    = 2'b10;
                branch       = 1'b1;
                pc_src       = 2'b01;
                next_state_s = S_FETCH;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_src       = 2'b10;
                next_state_s = S_FETCH;
            end
            S_HALT: begin
                halted       = 1'b1;
                next_state_s = S_HALT;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

`ifdef INSTR_COUNT_EN
    logic                 retire_s;
    logic [CNT_WIDTH-1:0] count_r;

    // Final cycle of every retired instruction; HALT and illegal paths never reach these
    always_comb begin
        retire_s = (state_r == S_WB_R) || (state_r == S_WB_MEM) ||
                   (state_r == S_BRANCH) || (state_r == S_JUMP) ||
                   ((state_r == S_MEM) && mem_ready && ir[5]);
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + CNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign instr_count = count_r;
`endif

endmodule

// File: tb/tb_nrisc_control_fsm.sv
// Table-driven bench for nrisc_control_fsm: one row per clock cycle plus hand-written reset/counter sequences.
// Counter checks are compiled only when INSTR_COUNT_EN is defined.
module tb_nrisc_control_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       mem_ready = 1'b0;
    logic       alu_op, mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic       branch, reg_write, mem_to_reg, halted, illegal_instr;
    logic [1:0] func_code, pc_src;
    logic [3:0] func_code_r;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    int tests  = 0;
    int failed = 0;

    nrisc_control_fsm #(.CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .alu_op(alu_op), .func_code(func_code), .func_code_r(func_code_r),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .branch(branch), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .halted(halted), .illegal_instr(illegal_instr)
`ifdef INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clock = ~clock;

    logic [18:0] act;
    assign act = {alu_op, func_code, func_code_r, mem_read, mem_write, i_or_d,
                  ir_write, pc_write, pc_src, branch, reg_write, mem_to_reg,
                  halted, illegal_instr};

    function automatic logic [18:0] mk(input logic a, input logic [1:0] fc, input logic [3:0] fr,
                                       input logic mr, input logic mw, input logic iod,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic br, input logic rw, input logic m2r,
                                       input logic h, input logic ill);
        mk = {a, fc, fr, mr, mw, iod, irw, pcw, pcs, br, rw, m2r, h, ill};
    endfunction

    typedef struct packed {
        logic        rst;
        logic [7:0]  ir;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] i, input logic m, input logic [18:0] e);
        vec_t v;
        v.rst = r; v.ir = i; v.rdy = m; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    logic [18:0] e_idle, e_fetch_rdy, e_fetch_wait, e_decode, e_decode_ill, e_exec_add, e_wb_add;
    logic [18:0] e_addr, e_mem_ld, e_mem_st, e_wb_mem, e_branch, e_jump, e_halt;

    initial begin
        e_idle       = mk(1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_fetch_rdy  = mk(1'b0, 2'b11, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_fetch_wait = mk(1'b0, 2'b11, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_decode     = e_idle;
        e_decode_ill = mk(1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e_exec_add   = mk(1'b1, 2'b01, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_wb_add     = mk(1'b1, 2'b01, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_addr       = mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_mem_ld     = mk(1'b1, 2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_mem_st     = mk(1'b1, 2'b00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_wb_mem     = mk(1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e_branch     = mk(1'b1, 2'b10, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_jump       = mk(1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_halt       = mk(1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // R add with zero-wait memory
        add(1'b1, 8'h7C, 1'b1, e_idle);
        add(1'b0, 8'h7C, 1'b1, e_idle);
        add(1'b0, 8'h7C, 1'b1, e_fetch_rdy);
        add(1'b0, 8'h7C, 1'b1, e_decode);
        add(1'b0, 8'h7C, 1'b1, e_exec_add);
        add(1'b0, 8'h7C, 1'b1, e_wb_add);
        // load, memory ready after three wait cycles
        add(1'b0, 8'h00, 1'b1, e_fetch_rdy);
        add(1'b0, 8'h00, 1'b1, e_decode);
        add(1'b0, 8'h00, 1'b1, e_addr);
        add(1'b0, 8'h00, 1'b0, e_mem_ld);
        add(1'b0, 8'h00, 1'b0, e_mem_ld);
        add(1'b0, 8'h00, 1'b0, e_mem_ld);
        add(1'b0, 8'h00, 1'b1, e_mem_ld);
        add(1'b0, 8'h00, 1'b1, e_wb_mem);
        // store goes straight back to FETCH
        add(1'b0, 8'h20, 1'b1, e_fetch_rdy);
        add(1'b0, 8'h20, 1'b1, e_decode);
        add(1'b0, 8'h20, 1'b1, e_addr);
        add(1'b0, 8'h20, 1'b1, e_mem_st);
        // branch, then jump
        add(1'b0, 8'h80, 1'b1, e_fetch_rdy);
        add(1'b0, 8'h80, 1'b1, e_decode);
        add(1'b0, 8'h80, 1'b1, e_branch);
        add(1'b0, 8'hC0, 1'b1, e_fetch_rdy);
        add(1'b0, 8'hC0, 1'b1, e_decode);
        add(1'b0, 8'hC0, 1'b1, e_jump);
        // fetch wait then jump
        add(1'b0, 8'hC0, 1'b0, e_fetch_wait);
        add(1'b0, 8'hC0, 1'b0, e_fetch_wait);
        add(1'b0, 8'hC0, 1'b1, e_fetch_rdy);
        add(1'b0, 8'hC0, 1'b1, e_decode);
        add(1'b0, 8'hC0, 1'b1, e_jump);
        // illegal R function halts with a single pulse
        add(1'b0, 8'h44, 1'b1, e_fetch_rdy);
        add(1'b0, 8'h44, 1'b1, e_decode_ill);
        add(1'b0, 8'h44, 1'b1, e_halt);
        add(1'b0, 8'h44, 1'b1, e_halt);
        // reset out of HALT, then HALT opcode without pulse
        add(1'b1, 8'hFF, 1'b1, e_idle);
        add(1'b0, 8'hFF, 1'b1, e_idle);
        add(1'b0, 8'hFF, 1'b1, e_fetch_rdy);
        add(1'b0, 8'hFF, 1'b1, e_decode);
        add(1'b0, 8'hFF, 1'b0, e_halt);
        add(1'b0, 8'hFF, 1'b1, e_halt);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            reset     = vecs[i].rst;
            ir        = vecs[i].ir;
            mem_ready = vecs[i].rdy;
            @(negedge clock);
            check($sformatf("row%0d", i), {13'd0, act}, {13'd0, vecs[i].exp});
        end

        // Reset asserted mid-cycle during a FETCH wait clears outputs immediately
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; ir = 8'h7C; mem_ready = 1'b0;
        @(posedge clock); #1;
        check("fetch_wait", {13'd0, act}, {13'd0, e_fetch_wait});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {13'd0, act}, {13'd0, e_idle});
`ifdef INSTR_COUNT_EN
        check("count_reset", {16'd0, instr_count}, 32'd0);
`endif

        // Three retired R instructions
        @(posedge clock); #1;
        reset = 1'b0; ir = 8'h7C; mem_ready = 1'b1;
        repeat (13) @(posedge clock);
        #1;
        check("after_three_r", {13'd0, act}, {13'd0, e_fetch_rdy});
`ifdef INSTR_COUNT_EN
        check("count_three", {16'd0, instr_count}, 32'd3);
        // illegal instruction must not count
        ir = 8'h44;
        repeat (3) @(posedge clock);
        #1;
        check("halt_after_ill", {13'd0, act}, {13'd0, e_halt});
        check("count_no_ill", {16'd0, instr_count}, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
